sim_run_ctrl: RTL and testbench



---
 rtl/sim_run_ctrl.sv | 150 +++++++++++++++
 tb/tb_sim_run_ctrl.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sim_run_ctrl.sv
// sim_run_ctrl: run-control harness between the top-level clock/reset and the core.
// It holds the core in reset for RST_CYCLES edges and then lets it run. In RUN it
// counts cycles and retired instructions. It ends the run on a store to the tohost
// mailbox (PASS/FAIL) or on a cycle limit (TIMEOUT). Terminal states keep the core in reset.
// Ports:
//   clk, rst (async, active-low)      clock and global reset
//   restart                           single-cycle pulse; re-enters HOLD and clears counters
//   st_valid/st_addr/st_data          data-memory store snoop
//   retire                            one instruction retired this cycle
//   cpu_rst                           active-high reset to the core
//   running/done/pass/timeout         run status (registered)
//   fail_code                         failing test number, nonzero only in FAIL
//   cycle_cnt/instret_cnt             RUN cycles / retired instructions
module sim_run_ctrl #(
  parameter int unsigned       RST_CYCLES     = 2,
  parameter int unsigned       TIMEOUT_CYCLES = 10,
  parameter int unsigned       CNT_W          = 32,
  parameter int unsigned       ADDR_W         = 32,
  parameter int unsigned       DATA_W         = 32,
  parameter logic [ADDR_W-1:0] TOHOST_ADDR    = 32'h0000_1000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              restart,
  input  logic              st_valid,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [DATA_W-1:0] st_data,
  input  logic              retire,
  output logic              cpu_rst,
  output logic              running,
  output logic              done,
  output logic              pass,
  output logic              timeout,
  output logic [DATA_W-1:0] fail_code,
  output logic [CNT_W-1:0]  cycle_cnt,
  output logic [CNT_W-1:0]  instret_cnt
);

  localparam int unsigned      HOLD_W    = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_CYCLES - 1);
  localparam bit               TO_EN     = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_HOLD,
    S_RUN,
    S_PASS,
    S_FAIL,
    S_TIMEOUT
  } state_t;

  state_t              state_q, state_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [CNT_W-1:0]    cyc_d, inst_d;
  logic [DATA_W-1:0]   fail_d;
  logic                cpu_rst_d, running_d, done_d, pass_d, timeout_d;
  logic                mbox_hit;

  // Odd data written to the mailbox terminates the run; even data is a no-op.
  assign mbox_hit = st_valid && (st_addr == TOHOST_ADDR) && st_data[0];

  // State, counters and decoded outputs all register on the same edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_HOLD;
      hold_q      <= '0;
      cpu_rst     <= 1'b1;
      running     <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      timeout     <= 1'b0;
      fail_code   <= '0;
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      cpu_rst     <= cpu_rst_d;
      running     <= running_d;
      done        <= done_d;
      pass        <= pass_d;
      timeout     <= timeout_d;
      fail_code   <= fail_d;
      cycle_cnt   <= cyc_d;
      instret_cnt <= inst_d;
    end
  end

  // Next state and counters; restart beats mailbox, mailbox beats timeout.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    cyc_d   = cycle_cnt;
    inst_d  = instret_cnt;
    fail_d  = fail_code;

    if (restart) begin
      state_d = S_HOLD;
      hold_d  = '0;
      cyc_d   = '0;
      inst_d  = '0;
      fail_d  = '0;
    end else begin
      case (state_q)
        S_HOLD: begin
          if (hold_q == HOLD_LAST) begin
            state_d = S_RUN;
            hold_d  = '0;
          end else begin
            hold_d = hold_q + HOLD_W'(1);
          end
        end
        S_RUN: begin
          // The terminating cycle is still counted.
          cyc_d = cycle_cnt + CNT_W'(1);
          if (retire) begin
            inst_d = instret_cnt + CNT_W'(1);
          end
          if (mbox_hit) begin
            if (st_data == DATA_W'(1)) begin
              state_d = S_PASS;
            end else begin
              state_d = S_FAIL;
              fail_d  = st_data >> 1;
            end
          end else if (TO_EN && (cycle_cnt == TO_LAST)) begin
            state_d = S_TIMEOUT;
          end
        end
        S_PASS, S_FAIL, S_TIMEOUT: begin
          state_d = state_q;
        end
        default: begin
          state_d = S_HOLD;
          hold_d  = '0;
        end
      endcase
    end
  end

  // Output decode from the next state so the flags line up with state_q.
  always_comb begin
    cpu_rst_d = (state_d != S_RUN);
    running_d = (state_d == S_RUN);
    done_d    = (state_d == S_PASS) || (state_d == S_FAIL) || (state_d == S_TIMEOUT);
    pass_d    = (state_d == S_PASS);
    timeout_d = (state_d == S_TIMEOUT);
  end

endmodule

// File: tb/tb_sim_run_ctrl.sv
// tb_sim_run_ctrl: directed scenarios plus randomized traffic for sim_run_ctrl.
// Two instances share the stimulus: one with the default 10-cycle timeout and one
// with the timeout disabled. A behavioural model tracks each instance, and every
// negedge compares both DUTs against their models.
module tb_sim_run_ctrl;

  localparam int RSTC = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        restart;
  logic        st_valid;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic        retire;

  logic        cpu_rst, running, done, pass, timeout;
  logic [31:0] fail_code, cycle_cnt, instret_cnt;
  logic        cpu_rst_z, running_z, done_z, pass_z, timeout_z;
  logic [31:0] fail_code_z, cycle_cnt_z, instret_cnt_z;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sim_run_ctrl dut (
    .clk(clk), .rst(rst), .restart(restart), .st_valid(st_valid), .st_addr(st_addr),
    .st_data(st_data), .retire(retire), .cpu_rst(cpu_rst), .running(running), .done(done),
    .pass(pass), .timeout(timeout), .fail_code(fail_code), .cycle_cnt(cycle_cnt),
    .instret_cnt(instret_cnt)
  );

  sim_run_ctrl #(.TIMEOUT_CYCLES(0)) dut_z (
    .clk(clk), .rst(rst), .restart(restart), .st_valid(st_valid), .st_addr(st_addr),
    .st_data(st_data), .retire(retire), .cpu_rst(cpu_rst_z), .running(running_z),
    .done(done_z), .pass(pass_z), .timeout(timeout_z), .fail_code(fail_code_z),
    .cycle_cnt(cycle_cnt_z), .instret_cnt(instret_cnt_z)
  );

  // Model: mode 0=hold 1=run 2=pass 3=fail 4=timeout; hold counts edges left.
  typedef struct {
    int          mode;
    int          hold;
    logic [31:0] cyc;
    logic [31:0] inst;
    logic [31:0] fc;
  } mdl_t;

  mdl_t m_a, m_z;

  function automatic mdl_t mreset();
    mdl_t n;
    n.mode = 0;
    n.hold = RSTC;
    n.cyc  = 0;
    n.inst = 0;
    n.fc   = 0;
    return n;
  endfunction

  function automatic mdl_t step(mdl_t m, int tmo, logic rs, logic sv, logic [31:0] a,
                                logic [31:0] d, logic rt);
    mdl_t n = m;
    if (rs) return mreset();
    case (m.mode)
      0: begin
        n.hold = m.hold - 1;
        if (n.hold == 0) n.mode = 1;
      end
      1: begin
        n.cyc = m.cyc + 1;
        if (rt) n.inst = m.inst + 1;
        if (sv && a == 32'h1000 && (d % 2) == 1) begin
          if (d == 1) n.mode = 2;
          else begin
            n.mode = 3;
            n.fc   = d / 2;
          end
        end else if (tmo != 0 && n.cyc == 32'(tmo)) begin
          n.mode = 4;
        end
      end
      default: ;
    endcase
    return n;
  endfunction

  function automatic logic [100:0] expv(mdl_t m);
    logic [31:0] f;
    f = (m.mode == 3) ? m.fc : 32'd0;
    return {m.mode != 1, m.mode == 1, m.mode >= 2, m.mode == 2, m.mode == 4, f, m.cyc, m.inst};
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_a <= mreset();
      m_z <= mreset();
    end else begin
      m_a <= step(m_a, 10, restart, st_valid, st_addr, st_data, retire);
      m_z <= step(m_z, 0, restart, st_valid, st_addr, st_data, retire);
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic cmp_models(input string tag);
    logic [100:0] ga, gz, ea, ez;
    ga = {cpu_rst, running, done, pass, timeout, fail_code, cycle_cnt, instret_cnt};
    gz = {cpu_rst_z, running_z, done_z, pass_z, timeout_z, fail_code_z, cycle_cnt_z, instret_cnt_z};
    ea = expv(m_a);
    ez = expv(m_z);
    total++;
    if (ga !== ea) begin
      bad++;
      $display("FAIL %s model_a: got %h want %h at %0t", tag, ga, ea, $time);
    end
    total++;
    if (gz !== ez) begin
      bad++;
      $display("FAIL %s model_z: got %h want %h at %0t", tag, gz, ez, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cmp_models("cycle");
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_restart();
    restart = 1'b1;
    tick();
    restart = 1'b0;
  endtask

  initial begin
    rst = 1'b0; restart = 1'b0; st_valid = 1'b0; st_addr = '0; st_data = '0; retire = 1'b0;
    ticks(2);
    chk("reset_cpu_rst", 32'(cpu_rst), 1);
    chk("reset_running", 32'(running), 0);
    rst = 1'b1;

    // Reset release then a full timeout with no stores.
    tick();
    chk("hold1_cpu_rst", 32'(cpu_rst), 1);
    tick();
    chk("run_entry", 32'(running), 1);
    chk("run_entry_cnt", cycle_cnt, 0);
    ticks(9);
    chk("pre_to_running", 32'(running), 1);
    tick();
    chk("to_flag", 32'(timeout), 1);
    chk("to_done", 32'(done), 1);
    chk("to_cnt", cycle_cnt, 10);
    chk("to_cpu_rst", 32'(cpu_rst), 1);

    // PASS at RUN cycle 4 with retire every cycle, then sticky.
    do_restart();
    chk("rs_cnt_clr", cycle_cnt, 0);
    chk("rs_to_clr", 32'(timeout), 0);
    retire = 1'b1;
    ticks(2);
    ticks(4);
    st_valid = 1'b1; st_addr = 32'h1000; st_data = 32'd1;
    tick();
    st_valid = 1'b0;
    chk("pass_flag", 32'(pass), 1);
    chk("pass_cnt", cycle_cnt, 5);
    chk("pass_inst", instret_cnt, 5);
    chk("pass_fc", fail_code, 0);
    ticks(20);
    chk("pass_sticky", 32'(pass), 1);
    chk("pass_sticky_cnt", cycle_cnt, 5);

    // Even store ignored, odd store fails.
    do_restart();
    ticks(2);
    st_valid = 1'b1; st_addr = 32'h1000; st_data = 32'd4;
    tick();
    chk("even_running", 32'(running), 1);
    st_data = 32'd7;
    tick();
    st_valid = 1'b0;
    chk("fail_code", fail_code, 3);
    chk("fail_pass", 32'(pass), 0);
    chk("fail_done", 32'(done), 1);

    // Wrong address ignored; PASS on the last timeout cycle wins.
    do_restart();
    ticks(2);
    st_valid = 1'b1; st_addr = 32'h1004; st_data = 32'd1;
    ticks(9);
    chk("wrong_addr_running", 32'(running), 1);
    chk("wrong_addr_cnt", cycle_cnt, 9);
    st_addr = 32'h1000;
    tick();
    st_valid = 1'b0;
    chk("last_pass", 32'(pass), 1);
    chk("last_no_to", 32'(timeout), 0);
    chk("last_cnt", cycle_cnt, 10);

    // Restart mid-RUN and from TIMEOUT reproduce the same timeout.
    do_restart();
    ticks(2);
    ticks(6);
    do_restart();
    chk("mid_rs_cpu_rst", 32'(cpu_rst), 1);
    chk("mid_rs_cnt", cycle_cnt, 0);
    tick();
    chk("mid_rs_hold", 32'(cpu_rst), 1);
    tick();
    ticks(10);
    chk("rerun_to", 32'(timeout), 1);
    chk("rerun_to_cnt", cycle_cnt, 10);
    do_restart();
    ticks(2);
    chk("rerun2_running", 32'(running), 1);
    ticks(10);
    chk("rerun2_to", 32'(timeout), 1);
    chk("rerun2_cnt", cycle_cnt, 10);

    // Asynchronous reset between edges mid-RUN.
    do_restart();
    ticks(5);
    #1 rst = 1'b0;
    #1;
    chk("async_cpu_rst", 32'(cpu_rst), 1);
    chk("async_running", 32'(running), 0);
    chk("async_cnt", cycle_cnt, 0);
    chk("async_inst", instret_cnt, 0);
    cmp_models("async");
    #2 rst = 1'b1;
    ticks(2);
    chk("async_rerun", 32'(running), 1);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      restart  = ($urandom_range(0, 63) == 0);
      st_valid = ($urandom_range(0, 3) == 0);
      st_addr  = ($urandom_range(0, 1) == 0) ? 32'h1000 : ((32'($urandom) & 32'hFFFC) | 32'h4);
      st_data  = ($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'($urandom_range(0, 9));
      retire   = ($urandom_range(0, 1) == 1);
      tick();
    end

    // Long run: timeout-disabled instance keeps running.
    restart = 1'b0; st_valid = 1'b0; retire = 1'b1;
    do_restart();
    ticks(2);
    ticks(1000);
    chk("notimeout_running", 32'(running_z), 1);
    chk("notimeout_flag", 32'(timeout_z), 0);
    chk("notimeout_cnt", cycle_cnt_z, 1000);
    chk("notimeout_inst", instret_cnt_z, 1000);
    chk("dflt_to_cnt", cycle_cnt, 10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
